// File: rtl/lsu_region_router.sv
// lsu_region_router: routes one LSU request to the address window it hits,
// returns the target's response and answers decode/align/timeout errors locally.
module lsu_region_router #(
  parameter int unsigned                NUM_REGION  = 4,
  parameter logic [NUM_REGION*32-1:0]   REGION_BASE = {32'h0000_0000, 32'h4000_0000,
                                                       32'h0000_1000, 32'h8000_0000},
  parameter logic [NUM_REGION*32-1:0]   REGION_END  = {32'h0000_FFFF, 32'h4000_FFFF,
                                                       32'h0002_0FFF, 32'h800F_FFFF},
  parameter int unsigned                TIMEOUT_CYC = 255,
  parameter bit                         CHECK_ALIGN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  input  logic [3:0]                 amo_i,
  input  logic [1:0]                 size_i,
  input  logic [3:0]                 strb_i,
  output logic                       ack_o,
  output logic                       error_o,
  output logic [31:0]                rdata_o,
  output logic [NUM_REGION-1:0]      dn_req_o,
  output logic                       dn_we_o,
  output logic [31:0]                dn_addr_o,
  output logic [31:0]                dn_wdata_o,
  output logic [3:0]                 dn_amo_o,
  output logic [1:0]                 dn_size_o,
  output logic [3:0]                 dn_strb_o,
  input  logic [NUM_REGION-1:0]      dn_ack_i,
  input  logic [NUM_REGION-1:0]      dn_error_i,
  input  logic [NUM_REGION*32-1:0]   dn_rdata_i,
  output logic [7:0]                 err_cnt_o
);

  localparam int unsigned    SW       = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1;
  localparam int unsigned    TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam bit             TMO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            any_hit;
  logic [SW-1:0]   sel_c, sel_q;
  logic            misaligned;
  logic            accept;
  logic            sel_ack, sel_err;
  logic [31:0]     sel_rdata;
  logic            tmo_hit, tmo_err;
  logic [TW-1:0]   timer_q;

  // Window decode; scanning high to low lets the lowest matching index win
  always_comb begin
    any_hit = 1'b0;
    sel_c   = '0;
    for (int i = NUM_REGION - 1; i >= 0; i--) begin
      if (addr_i >= REGION_BASE[i*32 +: 32] && addr_i <= REGION_END[i*32 +: 32]) begin
        any_hit = 1'b1;
        sel_c   = SW'(i);
      end
    end
  end

  assign misaligned = CHECK_ALIGN &&
                      ((size_i == 2'd1 && addr_i[0]) ||
                       (size_i == 2'd2 && addr_i[1:0] != 2'b00) ||
                       (size_i == 2'd3));

  assign accept  = (state_q == IDLE) && req_i && any_hit && !misaligned;
  assign tmo_hit = TMO_EN && (timer_q == TMO_LAST);

  // Response of the selected port only; other ports' acks are ignored
  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGION; i++) begin
      if (sel_q == SW'(i)) begin
        sel_ack   = dn_ack_i[i];
        sel_err   = dn_error_i[i];
        sel_rdata = dn_rdata_i[i*32 +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = (any_hit && !misaligned) ? BUSY : ERR;
      BUSY:    if (sel_ack || tmo_hit) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upstream response; a target ack in the timeout cycle takes priority
  always_comb begin
    ack_o   = 1'b0;
    error_o = 1'b0;
    rdata_o = '0;
    tmo_err = 1'b0;
    case (state_q)
      BUSY: begin
        if (sel_ack) begin
          ack_o   = 1'b1;
          error_o = sel_err;
          rdata_o = sel_rdata;
        end else if (tmo_hit) begin
          ack_o   = 1'b1;
          error_o = 1'b1;
          tmo_err = 1'b1;
        end
      end
      ERR: begin
        ack_o   = 1'b1;
        error_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture, downstream select and BUSY timer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dn_req_o   <= '0;
      dn_we_o    <= 1'b0;
      dn_addr_o  <= '0;
      dn_wdata_o <= '0;
      dn_amo_o   <= '0;
      dn_size_o  <= '0;
      dn_strb_o  <= '0;
      sel_q      <= '0;
      timer_q    <= '0;
    end else if (accept) begin
      dn_req_o   <= NUM_REGION'(1) << sel_c;
      dn_we_o    <= we_i;
      dn_addr_o  <= addr_i;
      dn_wdata_o <= wdata_i;
      dn_amo_o   <= amo_i;
      dn_size_o  <= size_i;
      dn_strb_o  <= strb_i;
      sel_q      <= sel_c;
      timer_q    <= '0;
    end else if (state_q == BUSY) begin
      if (sel_ack || tmo_hit) begin
        dn_req_o <= '0;
        timer_q  <= '0;
      end else begin
        timer_q  <= timer_q + TW'(1);
      end
    end
  end

  // Saturating count of locally generated errors
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if ((state_q == ERR || tmo_err) && err_cnt_o != 8'hFF) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_lsu_region_router.sv
// Testbench for lsu_region_router: scoreboard of expected upstream responses.
module tb_lsu_region_router;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  port;
    logic [7:0]  lat;
  } resp_t;

  logic         clk = 1'b0, rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0, we = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [3:0]   amo = '0, strb = '0;
  logic [1:0]   size = '0;
  logic [3:0]   dn_ack = '0, dn_error = '0;
  logic [127:0] dn_rdata = '0;

  logic ack_a, error_a, dn_we_a, ack_b, error_b, dn_we_b;
  logic [31:0] rdata_a, dn_addr_a, dn_wdata_a, rdata_b, dn_addr_b, dn_wdata_b;
  logic [3:0]  dn_req_a, dn_amo_a, dn_strb_a, dn_req_b, dn_amo_b, dn_strb_b;
  logic [1:0]  dn_size_a, dn_size_b;
  logic [7:0]  err_cnt_a, err_cnt_b;

  resp_t      sb[$];
  int         checks = 0, failures = 0;
  logic [7:0] exp_cnt = '0;

  always #5 clk = ~clk;

  lsu_region_router #(.TIMEOUT_CYC(4), .CHECK_ALIGN(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .amo_i(amo), .size_i(size), .strb_i(strb), .ack_o(ack_a), .error_o(error_a),
    .rdata_o(rdata_a), .dn_req_o(dn_req_a), .dn_we_o(dn_we_a), .dn_addr_o(dn_addr_a),
    .dn_wdata_o(dn_wdata_a), .dn_amo_o(dn_amo_a), .dn_size_o(dn_size_a),
    .dn_strb_o(dn_strb_a), .dn_ack_i(dn_ack), .dn_error_i(dn_error),
    .dn_rdata_i(dn_rdata), .err_cnt_o(err_cnt_a));

  lsu_region_router #(.TIMEOUT_CYC(4), .CHECK_ALIGN(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .amo_i(amo), .size_i(size), .strb_i(strb), .ack_o(ack_b), .error_o(error_b),
    .rdata_o(rdata_b), .dn_req_o(dn_req_b), .dn_we_o(dn_we_b), .dn_addr_o(dn_addr_b),
    .dn_wdata_o(dn_wdata_b), .dn_amo_o(dn_amo_b), .dn_size_o(dn_size_b),
    .dn_strb_o(dn_strb_b), .dn_ack_i(dn_ack), .dn_error_i(dn_error),
    .dn_rdata_i(dn_rdata), .err_cnt_o(err_cnt_b));

  // Drives one request, plays the target (acks after ack_after dn_req cycles, 0 = never)
  // and returns the observed response; port slice i always carries rd + i.
  task automatic run_req(input bit use_b, input logic [31:0] a, input logic w,
                         input logic [1:0] sz, input int ack_after, input logic de,
                         input logic [31:0] rd, output resp_t got, output int dncyc);
    logic [3:0] dq;
    logic       done;
    got = '0; got.lat = 8'hFF; dncyc = 0; done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (use_b) req_b = 1'b1; else req_a = 1'b1;
        we = w; addr = a; size = sz; strb = 4'hF; wdata = ~a; amo = a[7:4];
      end
      dq = use_b ? dn_req_b : dn_req_a;
      dn_ack = '0; dn_error = '0;
      for (int i = 0; i < 4; i++) dn_rdata[i*32 +: 32] = rd + 32'(i);
      if (dq != 4'b0) begin
        dncyc++;
        got.port = got.port | dq;
        if (ack_after != 0 && dncyc == ack_after) begin
          dn_ack = dq;
          dn_error = de ? dq : 4'b0;
        end
      end
      #1;
      if (use_b ? ack_b : ack_a) begin
        got.err   = use_b ? error_b : error_a;
        got.rdata = use_b ? rdata_b : rdata_a;
        got.lat   = 8'(c);
        done      = 1'b1;
      end
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; dn_ack = '0; dn_error = '0; dn_rdata = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack_a, error_a, rdata_a, dn_req_a, dn_we_a, dn_addr_a, dn_wdata_a, dn_amo_a,
         dn_size_a, dn_strb_a, err_cnt_a} !== '0) begin
      failures++;
      $display("FAIL reset_state outputs not zero: dn_req=%b ack=%b err_cnt=%h", dn_req_a, ack_a, err_cnt_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_routed();
    logic [31:0] ta [7];
    logic        tw [7];
    logic [1:0]  ts [7];
    int          tk [7];
    logic        td [7];
    int          tp [7];
    resp_t       got, e;
    int          dncyc;
    logic [31:0] rd;
    ta = '{32'h8009_0010, 32'h4000_0004, 32'h0000_1000, 32'h0000_0800,
           32'h0002_0FFF, 32'h800F_FFFC, 32'h8000_0000};
    tw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ts = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
    tk = '{3, 1, 2, 1, 2, 1, 1};
    td = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tp = '{0, 2, 1, 3, 1, 0, 0};
    for (int k = 0; k < 7; k++) begin
      rd = 32'hDEAD_BEEF + 32'(k * 16);
      sb.push_back({td[k], rd + 32'(tp[k]), 4'(1 << tp[k]), 8'(tk[k])});
      run_req(1'b0, ta[k], tw[k], ts[k], tk[k], td[k], rd, got, dncyc);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL routed[%0d] resp got=%h exp=%h", k, got, e);
      end
      checks++;
      if (dncyc != tk[k]) begin
        failures++;
        $display("FAIL routed[%0d] dn_req_cycles got=%0d exp=%0d", k, dncyc, tk[k]);
      end
      checks++;
      if ({dn_addr_a, dn_we_a, dn_size_a, dn_strb_a, dn_wdata_a, dn_amo_a} !==
          {ta[k], tw[k], ts[k], 4'hF, ~ta[k], ta[k][7:4]}) begin
        failures++;
        $display("FAIL routed[%0d] dn_fields got addr=%h we=%b size=%0d exp addr=%h", k,
                 dn_addr_a, dn_we_a, dn_size_a, ta[k]);
      end
    end
    checks++;
    if (err_cnt_a !== exp_cnt) begin
      failures++;
      $display("FAIL routed_err_cnt got=%h exp=%h", err_cnt_a, exp_cnt);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] ta [4];
    logic [1:0]  ts [4];
    resp_t       got, e;
    int          dncyc;
    ta = '{32'h9000_0000, 32'h0002_1000, 32'h7FFF_FFFC, 32'h4001_0000};
    ts = '{2'd2, 2'd0, 2'd2, 2'd0};
    for (int k = 0; k < 4; k++) begin
      sb.push_back({1'b1, 32'h0, 4'b0000, 8'd1});
      run_req(1'b0, ta[k], 1'b0, ts[k], 1, 1'b0, 32'h5A5A_0000, got, dncyc);
      exp_cnt = exp_cnt + 8'd1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL unmapped[%0d] resp got=%h exp=%h", k, got, e);
      end
      checks++;
      if (err_cnt_a !== exp_cnt) begin
        failures++;
        $display("FAIL unmapped[%0d] err_cnt got=%h exp=%h", k, err_cnt_a, exp_cnt);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ta [5];
    logic [1:0]  ts [5];
    logic        tbad [5];
    int          tp [5];
    resp_t       got, e;
    int          dncyc;
    ta   = '{32'h0000_1001, 32'h8000_0002, 32'h8000_0000, 32'h8000_0003, 32'h0000_1002};
    ts   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tbad = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tp   = '{1, 0, 0, 0, 1};
    for (int k = 0; k < 5; k++) begin
      if (tbad[k]) begin
        sb.push_back({1'b1, 32'h0, 4'b0000, 8'd1});
        exp_cnt = exp_cnt + 8'd1;
      end else begin
        sb.push_back({1'b0, 32'h0BAD_0000 + 32'(tp[k]), 4'(1 << tp[k]), 8'd1});
      end
      run_req(1'b0, ta[k], 1'b1, ts[k], 1, 1'b0, 32'h0BAD_0000, got, dncyc);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL align_a[%0d] resp got=%h exp=%h", k, got, e);
      end
    end
    checks++;
    if (err_cnt_a !== exp_cnt) begin
      failures++;
      $display("FAIL align_a err_cnt got=%h exp=%h", err_cnt_a, exp_cnt);
    end
    // Same misaligned half write with alignment checking disabled is routed
    sb.push_back({1'b0, 32'h7700_0001, 4'b0010, 8'd1});
    run_req(1'b1, 32'h0000_1001, 1'b1, 2'd1, 1, 1'b0, 32'h7700_0000, got, dncyc);
    e = sb.pop_front();
    checks++;
    if (got !== e || err_cnt_b !== 8'h00) begin
      failures++;
      $display("FAIL align_off resp got=%h exp=%h err_cnt=%h", got, e, err_cnt_b);
    end
  endtask

  task automatic test_unselected_ack();
    resp_t got, e;
    for (int i = 0; i < 4; i++) dn_rdata[i*32 +: 32] = 32'h3300_0000 + 32'(i);
    @(negedge clk);
    dn_ack = 4'b1111;
    #1;
    checks++;
    if (ack_a !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack_ignored ack got=%b exp=0", ack_a);
    end
    @(negedge clk);
    dn_ack = '0; req_a = 1'b1; we = 1'b0; addr = 32'h4000_0010; size = 2'd2; strb = 4'hF;
    sb.push_back({1'b0, 32'h3300_0002, 4'b0100, 8'd2});
    @(negedge clk);
    dn_ack = 4'b1011; dn_error = 4'b1011;
    #1;
    checks++;
    if (ack_a !== 1'b0 || dn_req_a !== 4'b0100) begin
      failures++;
      $display("FAIL unselected_ack ack got=%b dn_req=%b exp ack=0 dn_req=0100", ack_a, dn_req_a);
    end
    @(negedge clk);
    dn_ack = 4'b0100; dn_error = 4'b0000;
    #1;
    got = {error_a, rdata_a, dn_req_a, ack_a ? 8'd2 : 8'd0};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL selected_ack resp got=%h exp=%h", got, e);
    end
    @(negedge clk);
    req_a = 1'b0; dn_ack = '0; dn_error = '0; dn_rdata = '0;
  endtask

  task automatic test_timeout();
    resp_t got, e;
    int    dncyc;
    sb.push_back({1'b1, 32'h0, 4'b0100, 8'd4});
    run_req(1'b0, 32'h4000_0020, 1'b0, 2'd2, 0, 1'b0, 32'h6600_0000, got, dncyc);
    exp_cnt = exp_cnt + 8'd1;
    e = sb.pop_front();
    checks++;
    if (got !== e || dncyc != 4) begin
      failures++;
      $display("FAIL timeout resp got=%h exp=%h dn_req_cycles=%0d exp=4", got, e, dncyc);
    end
    @(negedge clk);
    dn_ack = 4'b0100; dn_rdata[95:64] = 32'h6600_0002;
    #1;
    checks++;
    if (ack_a !== 1'b0 || dn_req_a !== 4'b0000) begin
      failures++;
      $display("FAIL late_ack ack got=%b dn_req=%b exp 0", ack_a, dn_req_a);
    end
    @(negedge clk);
    dn_ack = '0; dn_rdata = '0;
    #1;
    checks++;
    if (err_cnt_a !== exp_cnt) begin
      failures++;
      $display("FAIL timeout_err_cnt got=%h exp=%h", err_cnt_a, exp_cnt);
    end
    // Target ack exactly in the last timeout cycle wins over the timeout
    sb.push_back({1'b0, 32'h6700_0002, 4'b0100, 8'd4});
    run_req(1'b0, 32'h4000_0024, 1'b0, 2'd2, 4, 1'b0, 32'h6700_0000, got, dncyc);
    e = sb.pop_front();
    checks++;
    if (got !== e || err_cnt_a !== exp_cnt) begin
      failures++;
      $display("FAIL ack_at_timeout resp got=%h exp=%h err_cnt=%h exp=%h", got, e, err_cnt_a, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    resp_t got, e;
    for (int i = 0; i < 4; i++) dn_rdata[i*32 +: 32] = 32'h1234_5678 + 32'(i);
    sb.push_back({1'b0, 32'h1234_5678, 4'b0001, 8'd2});
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; addr = 32'h8000_0100; wdata = 32'hAAAA_0001;
    size = 2'd2; strb = 4'hF; amo = 4'h1;
    @(negedge clk);
    addr = 32'h4000_0000; wdata = 32'h5555_5555; we = 1'b1; size = 2'd0; strb = 4'h1; amo = 4'h9;
    @(negedge clk);
    dn_ack = 4'b0001;
    #1;
    checks++;
    if ({dn_addr_a, dn_wdata_a, dn_we_a, dn_size_a, dn_strb_a, dn_amo_a} !==
        {32'h8000_0100, 32'hAAAA_0001, 1'b0, 2'd2, 4'hF, 4'h1}) begin
      failures++;
      $display("FAIL busy_fields_held got addr=%h wdata=%h we=%b", dn_addr_a, dn_wdata_a, dn_we_a);
    end
    got = {error_a, rdata_a, dn_req_a, ack_a ? 8'd2 : 8'd0};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b2b_first resp got=%h exp=%h", got, e);
    end
    @(negedge clk);
    dn_ack = '0; addr = 32'h4000_0008; we = 1'b1; wdata = 32'hCAFE_F00D;
    size = 2'd2; strb = 4'hC; amo = 4'h0;
    #1;
    checks++;
    if (ack_a !== 1'b0 || dn_req_a !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_idle ack got=%b dn_req=%b exp 0", ack_a, dn_req_a);
    end
    sb.push_back({1'b0, 32'h1234_567A, 4'b0100, 8'd1});
    @(negedge clk);
    dn_ack = 4'b0100;
    #1;
    checks++;
    if ({dn_addr_a, dn_wdata_a, dn_we_a, dn_size_a, dn_strb_a, dn_amo_a} !==
        {32'h4000_0008, 32'hCAFE_F00D, 1'b1, 2'd2, 4'hC, 4'h0}) begin
      failures++;
      $display("FAIL b2b_second_fields got addr=%h wdata=%h", dn_addr_a, dn_wdata_a);
    end
    got = {error_a, rdata_a, dn_req_a, ack_a ? 8'd1 : 8'd0};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b2b_second resp got=%h exp=%h", got, e);
    end
    @(negedge clk);
    req_a = 1'b0; dn_ack = '0; dn_rdata = '0;
    #1;
    checks++;
    if (ack_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end ack got=%b exp=0", ack_a);
    end
  endtask

  task automatic test_saturate();
    resp_t got, e;
    int    dncyc;
    for (int k = 0; k < 256; k++) begin
      sb.push_back({1'b1, 32'h0, 4'b0000, 8'd1});
      run_req(1'b0, 32'h9000_0000 + 32'(k * 4), 1'b0, 2'd2, 1, 1'b0, 32'h1, got, dncyc);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e = sb.pop_front();
      checks++;
      if (got !== e || err_cnt_a !== exp_cnt) begin
        failures++;
        $display("FAIL saturate[%0d] resp got=%h exp=%h err_cnt=%h exp=%h", k, got, e, err_cnt_a, exp_cnt);
      end
    end
    checks++;
    if (err_cnt_a !== 8'hFF) begin
      failures++;
      $display("FAIL err_cnt_saturated got=%h exp=ff", err_cnt_a);
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; addr = 32'h8000_0040; size = 2'd2; strb = 4'hF;
    @(negedge clk);
    #1;
    checks++;
    if (dn_req_a !== 4'b0001) begin
      failures++;
      $display("FAIL rst_busy_pre dn_req got=%b exp=0001", dn_req_a);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack_a, error_a, rdata_a, dn_req_a, dn_we_a, dn_addr_a, dn_wdata_a, dn_amo_a,
         dn_size_a, dn_strb_a, err_cnt_a} !== '0) begin
      failures++;
      $display("FAIL rst_busy outputs got dn_req=%b dn_addr=%h err_cnt=%h exp 0", dn_req_a, dn_addr_a, err_cnt_a);
    end
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ack_a !== 1'b0 || dn_req_a !== 4'b0000) begin
        failures++;
        $display("FAIL rst_busy_after[%0d] ack=%b dn_req=%b exp 0", c, ack_a, dn_req_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_routed();
    test_unmapped();
    test_misalign();
    test_unselected_ack();
    test_timeout();
    test_back_to_back();
    test_saturate();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
